mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU control/datapath and the debug unit (DBU).
- Serialises word accesses through a small FSM, sequences the memory read latency, and returns a one-cycle ack with captured read data.
- Provides round-robin fairness, plus a debug hold that blocks new CPU accesses while the DBU inspects or patches memory.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between the CPU and the debug unit.
// Round-robin on ties, debug hold blocks new CPU grants, one-cycle ack with captured read data.
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  input  logic          dbu_req,
  input  logic          dbu_we,
  input  logic [AW-1:0] dbu_addr,
  input  logic [DW-1:0] dbu_wdata,
  output logic [DW-1:0] dbu_rdata,
  output logic          dbu_ack,
  input  logic          dbu_hold,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  // state  | meaning
  // IDLE   | arbitrate eligible requests, grant one
  // ACCESS | drive memory: write for 1 cycle, read for RD_LAT+1 cycles
  // ACK    | one-cycle ack to the granted requester
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

  state_t     state, state_nx;
  logic       last_dbu, gnt_dbu, we_q;
  logic [1:0] cnt;
  logic       cpu_elig, dbu_elig, grant, pick_dbu;

  assign cpu_elig = cpu_req & ~dbu_hold;
  assign dbu_elig = dbu_req;
  assign grant    = cpu_elig | dbu_elig;
  // On a tie the side that did not win last time gets the port
  assign pick_dbu = dbu_elig & (~cpu_elig | ~last_dbu);

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    cpu_ack  = 1'b0;
    dbu_ack  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:   if (grant) state_nx = ACCESS;
      ACCESS: begin
        mem_we = we_q;
        if (we_q || cnt == 2'd0) state_nx = ACK;
      end
      ACK: begin
        cpu_ack  = ~gnt_dbu;
        dbu_ack  = gnt_dbu;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    cpu_wait = cpu_req & ~cpu_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_dbu  <= 1'b1;
      gnt_dbu   <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbu_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant) begin
        gnt_dbu   <= pick_dbu;
        last_dbu  <= pick_dbu;
        we_q      <= pick_dbu ? dbu_we    : cpu_we;
        mem_addr  <= pick_dbu ? dbu_addr  : cpu_addr;
        mem_wdata <= pick_dbu ? dbu_wdata : cpu_wdata;
        cnt       <= LAT_LOAD;
      end
      // Read data is valid on the edge that ends the last ACCESS cycle
      if (state == ACCESS && !we_q) begin
        if (cnt == 2'd0) begin
          if (gnt_dbu) dbu_rdata <= mem_rdata;
          else         cpu_rdata <= mem_rdata;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-timeline reference model,
// synchronous memory model, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dbu_req, dbu_we, dbu_hold;
  logic [AW-1:0] cpu_addr, dbu_addr;
  logic [DW-1:0] cpu_wdata, dbu_wdata;
  logic [DW-1:0] cpu_rdata, dbu_rdata;
  logic          cpu_ack, cpu_wait, dbu_ack, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .dbu_req(dbu_req), .dbu_we(dbu_we), .dbu_addr(dbu_addr), .dbu_wdata(dbu_wdata),
    .dbu_rdata(dbu_rdata), .dbu_ack(dbu_ack), .dbu_hold(dbu_hold),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Memory: unwritten words read as {24'h100000, addr}; one-cycle synchronous read
  bit          wr_valid [256];
  logic [31:0] wr_data  [256];

  function automatic logic [31:0] mem_val(input logic [7:0] a);
    return wr_valid[a] ? wr_data[a] : {24'h100000, a};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      wr_valid[mem_addr] <= 1'b1;
      wr_data[mem_addr]  <= mem_wdata;
    end
    mem_rdata <= mem_val(mem_addr);
  end

  // Reference model: a transaction occupies m_len cycles after its grant,
  // the last of which is the ack cycle; IDLE is the cycle with m_t == 0.
  int          m_t, m_len;
  bit          m_last_dbu, m_owner, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_cpu_rd, m_dbu_rd;

  function automatic bit model_pick(input bit ce, input bit de, input bit last_dbu);
    if (ce && de) return !last_dbu;
    return de;
  endfunction

  bit m_pick;
  assign m_pick = model_pick(cpu_req && !dbu_hold, dbu_req, m_last_dbu);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_len <= 0; m_last_dbu <= 1'b1; m_owner <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_cpu_rd <= '0; m_dbu_rd <= '0;
    end else if (m_t == 0) begin
      if ((cpu_req && !dbu_hold) || dbu_req) begin
        m_owner    <= m_pick;
        m_last_dbu <= m_pick;
        m_we       <= m_pick ? dbu_we : cpu_we;
        m_addr     <= m_pick ? dbu_addr : cpu_addr;
        m_wdata    <= m_pick ? dbu_wdata : cpu_wdata;
        m_len      <= (m_pick ? dbu_we : cpu_we) ? 2 : RD_LAT + 2;
        m_t        <= 1;
      end
    end else if (m_t == m_len) begin
      m_t <= 0;
    end else begin
      if (!m_we && m_t == m_len - 1) begin
        if (m_owner) m_dbu_rd <= mem_val(m_addr);
        else         m_cpu_rd <= mem_val(m_addr);
      end
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  bit e_cpu_ack, e_dbu_ack;
  always @(negedge clk) begin
    e_cpu_ack = (m_t != 0) && (m_t == m_len) && !m_owner;
    e_dbu_ack = (m_t != 0) && (m_t == m_len) && m_owner;
    chk_b("busy", busy, m_t != 0);
    chk_b("mem_we", mem_we, (m_t == 1) && m_we);
    chk_b("cpu_ack", cpu_ack, e_cpu_ack);
    chk_b("dbu_ack", dbu_ack, e_dbu_ack);
    chk_b("cpu_wait", cpu_wait, cpu_req && !e_cpu_ack);
    chk("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("dbu_rdata", dbu_rdata, m_dbu_rd);
  end

  // Drives one request from a posedge+1 instant; returns ack cycle index after E0
  task automatic do_txn(input bit use_dbu, input bit we, input logic [7:0] a,
                        input logic [31:0] wd, output int lat, output int we_cnt,
                        output logic [31:0] rd);
    logic ack;
    if (use_dbu) begin dbu_req = 1; dbu_we = we; dbu_addr = a; dbu_wdata = wd; end
    else         begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    lat = 0; we_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
      ack = use_dbu ? dbu_ack : cpu_ack;
    end while (!ack && lat < 50);
    chk_b("txn_ack_seen", ack, 1'b1);
    rd = use_dbu ? dbu_rdata : cpu_rdata;
    @(posedge clk); #1;
    if (use_dbu) dbu_req = 0; else cpu_req = 0;
    lat = lat - 1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat, wec, n, k, t, prev;
    logic [31:0] rd;
    bit ca, da, cpend, dpend, cpu_seen, dbu_done;

    rst_n = 0; dbu_hold = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; cpu_wdata = '0;
    dbu_req = 1; dbu_we = 0; dbu_addr = 8'h30; dbu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_mem_we", mem_we, 1'b0);
    chk_b("rst_acks", cpu_ack | dbu_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    rst_n = 1;

    // First tie after reset goes to the CPU, then the DBU
    n = 0;
    do begin @(negedge clk); n++; end while (!(cpu_ack || dbu_ack) && n < 50);
    chk_b("first_tie_cpu", cpu_ack, 1'b1);
    @(posedge clk); #1 cpu_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dbu_ack && n < 50);
    chk_b("second_dbu", dbu_ack, 1'b1);
    chk("dbu_rdata_30", dbu_rdata, 32'h10000030);
    @(posedge clk); #1 dbu_req = 0;

    do_txn(0, 0, 8'h10, 32'h0, lat, wec, rd);
    chk("cpu_rd_lat", lat, 3);
    chk("cpu_rd_we_cnt", wec, 0);
    chk("cpu_rdata_10", rd, 32'h10000010);
    chk("dbu_rdata_kept", dbu_rdata, 32'h10000030);

    do_txn(1, 1, 8'h20, 32'hDEADBEEF, lat, wec, rd);
    chk("dbu_wr_lat", lat, 2);
    chk("dbu_wr_we_cnt", wec, 1);
    do_txn(1, 0, 8'h20, 32'h0, lat, wec, rd);
    chk("dbu_rd_lat", lat, 3);
    chk("dbu_rdata_20", rd, 32'hDEADBEEF);
    chk("cpu_rdata_kept", cpu_rdata, 32'h10000010);

    // Contention: last grant was DBU, so acks go CPU, DBU, ... every RD_LAT+3 cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h11;
    dbu_req = 1; dbu_we = 0; dbu_addr = 8'h21;
    k = 0; t = 0; prev = 0;
    while (k < 6 && t < 100) begin
      @(negedge clk); t++;
      if (cpu_ack || dbu_ack) begin
        chk_b("rr_order", dbu_ack, k[0]);
        if (k > 0) chk("rr_spacing", t - prev, RD_LAT + 3);
        prev = t; k++;
      end
    end
    chk("rr_ack_count", k, 6);
    @(posedge clk); #1 cpu_req = 0; dbu_req = 0;

    // Debug hold: CPU stays pending while a DBU read is serviced
    dbu_hold = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    dbu_req = 1; dbu_we = 0; dbu_addr = 8'h41;
    cpu_seen = 0; dbu_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack) cpu_seen = 1;
      da = dbu_ack;
      if (da) dbu_done = 1;
      chk_b("hold_cpu_wait", cpu_wait, 1'b1);
      @(posedge clk); #1;
      if (da) dbu_req = 0;
    end
    chk_b("hold_no_cpu_ack", cpu_seen, 1'b0);
    chk_b("hold_dbu_served", dbu_done, 1'b1);
    chk("hold_dbu_rdata", dbu_rdata, 32'h10000041);
    dbu_hold = 0;
    do_txn(0, 0, 8'h40, 32'h0, lat, wec, rd);
    chk("hold_release_lat", lat, 3);
    chk("hold_cpu_rdata", rd, 32'h10000040);

    // Reset during a CPU write ACCESS cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h50; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk_b("pre_rst_mem_we", mem_we, 1'b1);
    #1 rst_n = 0;
    #1 chk_b("rst_mem_we_drop", mem_we, 1'b0);
    @(negedge clk);
    chk_b("rst_no_cpu_ack", cpu_ack, 1'b0);
    cpu_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_no_write", mem_val(8'h50), 32'h10000050);
    @(negedge clk);
    chk_b("rst_idle", busy, 1'b0);
    @(posedge clk); #1;
    do_txn(0, 1, 8'h50, 32'hCAFEF00D, lat, wec, rd);
    chk("retry_wr_lat", lat, 2);
    chk("retry_we_cnt", wec, 1);
    do_txn(0, 0, 8'h50, 32'h0, lat, wec, rd);
    chk("retry_readback", rd, 32'hCAFEF00D);

    // Randomized traffic against the model
    cpend = 0; dpend = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); ca = cpu_ack; da = dbu_ack;
      @(posedge clk); #1;
      if (ca) begin cpend = 0; cpu_req = 0; end
      if (da) begin dpend = 0; dbu_req = 0; end
      if (!cpend && $urandom_range(2) == 0) begin
        cpend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(1));
        cpu_addr = 8'($urandom_range(15)); cpu_wdata = $urandom;
      end
      if (!dpend && $urandom_range(2) == 0) begin
        dpend = 1; dbu_req = 1; dbu_we = 1'($urandom_range(1));
        dbu_addr = 8'($urandom_range(15)); dbu_wdata = $urandom;
      end
      if ($urandom_range(7) == 0) dbu_hold = ~dbu_hold;
    end
    dbu_hold = 0;
    for (int i = 0; i < 60 && (cpend || dpend); i++) begin
      @(negedge clk); ca = cpu_ack; da = dbu_ack;
      @(posedge clk); #1;
      if (ca) begin cpend = 0; cpu_req = 0; end
      if (da) begin dpend = 0; dbu_req = 0; end
    end
    chk_b("rand_drained", cpend | dpend, 1'b0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
